// File: rtl/demux_stream_router.sv
// demux_stream_router
//   1-to-NCH stream demultiplexer. A word offered on the input is routed to the
//   channel named by in_sel_i. Each channel holds at most one word in an output
//   register, and that word stays there until the consumer of that channel takes
//   it. A select value >= NCH is never routed: the word is accepted, dropped, and
//   reported on err_sel_o.
//
//   Optional build macro: DEMUX_STATS_EN. When it is defined, each channel has a
//   saturating handshake counter. The counters are read through stat_sel_i and
//   stat_cnt_o.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   input word valid
//   in_ready_o   input may transfer this cycle (combinational, independent of in_valid_i)
//   in_data_i    input word (DW bits)
//   in_sel_i     destination channel (SW bits)
//   out_valid_o  per-channel valid, bit k = channel k
//   out_ready_i  per-channel consumer ready
//   out_data_o   channel k in bits [k*DW +: DW]
//   err_sel_o    one-cycle pulse after an out-of-range word was dropped
//   stat_sel_i   counter read select       (DEMUX_STATS_EN only)
//   stat_cnt_o   counter read data         (DEMUX_STATS_EN only)
//
// Per-channel state
//   state   | meaning
//   EMPTY   | output register holds no word, out_valid_o[k] = 0
//   FULL    | output register holds a word, out_valid_o[k] = 1
module demux_stream_router #(
  parameter int DW    = 8,
  parameter int NCH   = 4,
  parameter int SW    = $clog2(NCH),
  parameter int CNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DW-1:0]     in_data_i,
  input  logic [SW-1:0]     in_sel_i,
  output logic [NCH-1:0]    out_valid_o,
  input  logic [NCH-1:0]    out_ready_i,
  output logic [NCH*DW-1:0] out_data_o,
  output logic              err_sel_o
`ifdef DEMUX_STATS_EN
  ,
  input  logic [SW-1:0]     stat_sel_i,
  output logic [CNT_W-1:0]  stat_cnt_o
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } ch_state_e;

  ch_state_e         state_q [NCH];
  logic [DW-1:0]     data_q  [NCH];
  logic              err_q;

  logic [NCH-1:0]    sel_hit;
  logic              sel_ok;
  logic              xfer;
  logic [NCH-1:0]    wr;

  // One-hot decode of the select. Comparing against the integer value also
  // handles NCH that is not a power of two: codes >= NCH decode to no channel.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      sel_hit[k] = (int'(in_sel_i) == k);
    end
  end

  assign sel_ok     = |sel_hit;
  // A bad select is always accepted so that it gets dropped. A good select is
  // accepted when the target register is free now or is drained on this edge.
  assign in_ready_o = !sel_ok || |(sel_hit & (~out_valid_o | out_ready_i));
  assign xfer       = in_valid_i && in_ready_o;
  assign wr         = xfer ? sel_hit : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= S_EMPTY;
        data_q[k]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      err_q <= xfer && !sel_ok;
      for (int k = 0; k < NCH; k++) begin
        case (state_q[k])
          S_EMPTY: begin
            if (wr[k]) begin
              state_q[k] <= S_FULL;
              data_q[k]  <= in_data_i;
            end
          end
          S_FULL: begin
            // While FULL, a write to k can only happen when out_ready_i[k] is
            // high, so the old word is consumed on the same edge it is replaced.
            if (wr[k]) begin
              data_q[k] <= in_data_i;
            end else if (out_ready_i[k]) begin
              state_q[k] <= S_EMPTY;
            end
          end
          default: state_q[k] <= S_EMPTY;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign out_valid_o[k]           = (state_q[k] == S_FULL);
    assign out_data_o[k*DW +: DW]   = data_q[k];
  end

  assign err_sel_o = err_q;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [NCH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (out_valid_o[k] && out_ready_i[k] && (cnt_q[k] != '1)) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    stat_cnt_o = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(stat_sel_i) == k) begin
        stat_cnt_o = cnt_q[k];
      end
    end
  end
`endif

endmodule
